// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / video refresh) memory bus arbiter with address-decoded chip selects and per-region wait states.
// Latency: grant on the first edge with a request pending; ack (WS+1) cycles after the grant edge; one IDLE cycle between accesses.
// Backpressure: a request is held until its ack; requests arriving mid-access wait; ties are resolved round-robin.
module mem_bus_arbiter #(
  parameter int WS_ROM = 2,
  parameter int WS_RAM = 1,
  parameter int WS_VR  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [19:0] cpu_addr,
  input  logic        cpu_we,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic        vid_ack,
  output logic [19:0] bus_addr,
  output logic        bus_we,
  output logic        cs_rom,
  output logic [3:0]  cs_ram,
  output logic        cs_vr,
  output logic        busy
);

  localparam int MAX_AB  = (WS_ROM > WS_RAM) ? WS_ROM : WS_RAM;
  localparam int MAX_WS  = (MAX_AB > WS_VR) ? MAX_AB : WS_VR;
  localparam int WCNT_W  = (MAX_WS > 0) ? $clog2(MAX_WS + 1) : 1;

  localparam logic [WCNT_W-1:0] WS_ROM_C = WS_ROM[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] WS_RAM_C = WS_RAM[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0] WS_VR_C  = WS_VR[WCNT_W-1:0];

  typedef enum logic {IDLE, ACCESS} state_t;

  // sel bit order: {vr, ram[3:0], rom}
  function automatic logic [5:0] decode(input logic [19:0] a);
    logic [5:0] s;
    s = 6'b000000;
    if (a < 20'h04000)        s[0] = 1'b1;
    else if (a[19:18] == 2'd0) s[1] = 1'b1;
    else if (a[19:18] == 2'd1) s[2] = 1'b1;
    else if (a[19:18] == 2'd2) s[3] = 1'b1;
    else if (a < 20'hF0000)   s[4] = 1'b1;
    else                      s[5] = 1'b1;
    return s;
  endfunction

  function automatic logic [WCNT_W-1:0] ws_of(input logic [5:0] s);
    logic [WCNT_W-1:0] w;
    w = WS_RAM_C;
    if (s[0]) w = WS_ROM_C;
    if (s[5]) w = WS_VR_C;
    return w;
  endfunction

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              lg, lg_nxt;
  logic [19:0]       addr_nxt;
  logic              we_nxt;
  logic [5:0]        sel, sel_nxt;
  logic              busy_nxt;
  logic              win_vid;

  // lg == 1 means video went last, so the CPU takes a tie.
  assign win_vid = (cpu_req && vid_req) ? ~lg : vid_req;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    lg_nxt    = lg;
    addr_nxt  = bus_addr;
    we_nxt    = bus_we;
    sel_nxt   = sel;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (cpu_req || vid_req) begin
          state_nxt = ACCESS;
          lg_nxt    = win_vid;
          addr_nxt  = win_vid ? vid_addr : cpu_addr;
          we_nxt    = win_vid ? 1'b0 : cpu_we;
          sel_nxt   = decode(addr_nxt);
          wcnt_nxt  = ws_of(sel_nxt);
          busy_nxt  = 1'b1;
        end
      end
      ACCESS: begin
        if (wcnt != '0) begin
          wcnt_nxt = wcnt - WCNT_W'(1);
        end else begin
          state_nxt = IDLE;
          sel_nxt   = 6'b000000;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 6'b000000;
        busy_nxt  = 1'b0;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wcnt     <= '0;
      lg       <= 1'b1;
      bus_addr <= 20'h00000;
      bus_we   <= 1'b0;
      sel      <= 6'b000000;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      lg       <= lg_nxt;
      bus_addr <= addr_nxt;
      bus_we   <= we_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
    end
  end

  // lg holds the current grantee for the whole access.
  assign cpu_ack = (state == ACCESS) && (wcnt == '0) && !lg;
  assign vid_ack = (state == ACCESS) && (wcnt == '0) && lg;

  assign cs_rom = sel[0];
  assign cs_ram = sel[4:1];
  assign cs_vr  = sel[5];

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter WS_ROM, default 2, ROM wait-state count.
REQ-002 Parameter WS_RAM, default 1, wait-state count for each RAM bank.
REQ-003 Parameter WS_VR, default 0, VRAM wait-state count.
REQ-004 clk  input  1  single system clock, rising-edge active.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 cpu_req  input  1  CPU access request, held high until cpu_ack.
REQ-007 cpu_addr  input  20  CPU byte address.
REQ-008 cpu_we  input  1  CPU write enable (1 = write).
REQ-009 cpu_ack  output  1  one-cycle CPU access-complete pulse.
REQ-010 vid_req  input  1  video-refresh read request, held high until vid_ack.
REQ-011 vid_addr  input  20  video-refresh byte address.
REQ-012 vid_ack  output  1  one-cycle video access-complete pulse.
REQ-013 bus_addr  output  20  latched address of the granted master.
REQ-014 bus_we  output  1  latched write enable (always 0 for video grants).
REQ-015 cs_rom  output  1  ROM chip select, active-high.
REQ-016 cs_ram  output  4  RAM bank chip selects, one-hot, active-high.
REQ-017 cs_vr  output  1  VRAM chip select, active-high.
REQ-018 busy  output  1  high while an access is in progress.

Function
REQ-019 Map decode of the latched address: ROM 0x00000-0x03FFF; cs_ram[0] 0x04000-0x3FFFF; cs_ram[1] 0x40000-0x7FFFF; cs_ram[2] 0x80000-0xBFFFF; cs_ram[3] 0xC0000-0xEFFFF; VRAM 0xF0000-0xFFFFF.
REQ-020 The full 20-bit space is decoded, so every access drives exactly one select.
REQ-021 FSM states are IDLE and ACCESS; it holds a wait counter wcnt and a last-grant flag lg (0 = CPU, 1 = video).
REQ-022 In IDLE with any request pending, the next edge enters ACCESS and latches the winner's address and we into bus_addr and bus_we.
REQ-023 On the same edge, wcnt loads the wait-state count of the decoded region.
REQ-024 Arbitration in IDLE: a sole requester wins; if both request, the master not equal to lg wins (round-robin).
REQ-025 lg updates to the winner on the grant edge.
REQ-026 All chip selects and busy are registered; they are high for every cycle in ACCESS and low in IDLE.
REQ-027 In ACCESS with wcnt > 0, wcnt decrements each cycle.
REQ-028 In ACCESS with wcnt = 0, the granted master's ack is high for that cycle and the next edge returns to IDLE.
REQ-029 Access length is WS+1 cycles, and the request-to-ack latency is WS+1 cycles after the grant edge.
REQ-030 At least one IDLE cycle separates consecutive accesses; a master holding req after its ack is re-arbitrated in that cycle.
REQ-031 A request deasserted mid-access is ignored: the access completes and the ack is still pulsed.
REQ-032 A request arriving during ACCESS waits; it is never dropped.
REQ-033 Address or we changes during ACCESS have no effect on bus_addr or bus_we.
REQ-034 cpu_ack and vid_ack are never high together.
REQ-035 The wait counter is wide enough for the largest parameter; a wait-state count of 0 gives a single-cycle access.

Reset
REQ-036 rst_n low, asynchronously and at any time including mid-access: state IDLE, wcnt 0, lg 1 (CPU wins the first tie), bus_addr 0, bus_we 0, all selects 0, busy 0, both acks 0.
REQ-037 An access interrupted by reset is abandoned with no ack.
REQ-038 After rst_n is released, arbitration resumes on the first rising edge.

Verification
REQ-039 CPU read, cpu_addr=0x03FFF, default WS -> cs_rom high for 3 cycles, cpu_ack on the 3rd, bus_addr=0x03FFF.
REQ-040 CPU write, addr=0x40000 and then addr=0xEFFFF -> cs_ram=0010 for 2 cycles with bus_we=1, then cs_ram=1000 for 2 cycles.
REQ-041 vid_req with addr=0xF0000 -> cs_vr high for 1 cycle with vid_ack in the same cycle; bus_we=0.
REQ-042 Both masters request continuously after reset -> grants alternate CPU, video, CPU, ..., with one IDLE cycle between accesses and never two simultaneous acks.
REQ-043 cpu_req dropped in the 2nd ROM wait cycle -> access completes and cpu_ack pulses on the 3rd cycle.
REQ-044 rst_n pulsed low during a RAM access -> all outputs 0 immediately with no ack; after release, a pending request is granted to the CPU first.
